gray_conv_sched: RTL

GRAY_CONV_SCHED -- requirements
Module: gray_conv_sched

---
 rtl/gray_conv_pkg.sv | 16 +
 rtl/rr_arb2.sv | 24 ++
 rtl/gray_conv_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg -- shared definitions for the Gray-to-binary conversion scheduler.
//   state_t       : scheduler FSM states (IDLE, CONV, DONE)
//   DEFAULT_WIDTH : default Gray code width in bits
//   NUM_REQ       : number of requesters sharing the converter
package gray_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int NUM_REQ       = 2;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin arbiter (purely combinational).
//   req  [1:0] : request per requester
//   last       : index of the requester served most recently
//   gnt  [1:0] : one-hot grant, all-zero when nobody requests
// On a tie the requester that was not served last wins.
module rr_arb2
  import gray_conv_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/gray_conv_sched.sv
// gray_conv_sched -- arbitrates two requesters onto one bit-serial
// Gray-to-binary converter.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   req[1:0] : conversion request per requester
//   gray0/1  : Gray-coded operand of requester 0/1
//   gnt[1:0] : one-hot grant, high while the owner's conversion runs
//   busy     : high in CONV and DONE
//   done     : one-cycle completion pulse
//   done_id  : requester index of the last completed conversion
//   bin      : binary result of the last completed conversion
// A conversion takes WIDTH cycles in CONV (one result bit per cycle, MSB
// first) followed by one DONE cycle, so captures are at least WIDTH+2
// cycles apart.
module gray_conv_sched
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [WIDTH-1:0]     gray0,
  input  logic [WIDTH-1:0]     gray1,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic [WIDTH-1:0]     bin
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t                r_state;
  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_done;
  logic                  r_done_id;
  logic [WIDTH-1:0]      r_bin;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_shift;
  logic                  r_last;

  logic [NUM_REQ-1:0]    w_pick;
  logic [WIDTH-1:0]      w_sel_gray;
  logic                  w_prev;
  logic                  w_bit;
  logic                  w_last_cnt;

  rr_arb2 u_arb (
    .req  (req),
    .last (r_last),
    .gnt  (w_pick)
  );

  assign w_sel_gray = w_pick[1] ? gray1 : gray0;

  // The shift register serves double duty: Gray bits leave at the MSB while
  // resolved binary bits enter at the LSB. After WIDTH shifts it holds the
  // full result. The previously resolved bit therefore sits in r_shift[0],
  // except on the first cycle where the MSB has no predecessor.
  assign w_prev     = (r_cnt == '0) ? 1'b0 : r_shift[0];
  assign w_bit      = r_shift[WIDTH-1] ^ w_prev;
  assign w_last_cnt = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_shift   <= '0;
      // Pretend requester 1 was served last so requester 0 wins the first tie.
      r_last    <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_pick != '0) begin
            r_shift <= w_sel_gray;
            r_gnt   <= w_pick;
            r_cnt   <= '0;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_shift <= {r_shift[WIDTH-2:0], w_bit};
          r_cnt   <= r_cnt + 1'b1;
          if (w_last_cnt) begin
            r_bin     <= {r_shift[WIDTH-2:0], w_bit};
            r_done_id <= r_gnt[1];
            r_last    <= r_gnt[1];
            r_gnt     <= '0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_gnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = (r_state == CONV) || (r_state == DONE);
  assign done    = r_done;
  assign done_id = r_done_id;
  assign bin     = r_bin;

endmodule
